// File: rtl/byteblast_pkg.sv
// Shared types and constants for the ram_streamer access engine.
package byteblast_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } stream_state_t;

    localparam int unsigned RAM_READ_LATENCY = 1;
    localparam int unsigned OUT_BUFFER_DEPTH = 2;

endpackage

// File: rtl/ram_streamer_fifo2.sv
// Two-entry buffer that holds RAM read data until the dump stream accepts it.
module fifo2 #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] head,
    output logic [1:0]           occupancy
);

    logic [DATA_BITS-1:0] slot [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;

    // NOTE: registers update with <= so every branch sees the pre-edge values of its neighbours.
    // NOTE: the two slots are reset too, so the head (and out_data) reads 0 out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= '0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= push_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head      = slot[rd_ptr];
    assign occupancy = count;

endmodule

// File: rtl/ram_streamer.sv
// Command-driven burst engine: loads a byte stream into the RAM or dumps RAM bytes onto a stream.
module ram_streamer
    import byteblast_pkg::*;
#(
    parameter int ADDRESS_BITS = 6,
    parameter int DATA_BITS    = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESS_BITS-1:0] cmd_address,
    input  logic [ADDRESS_BITS-1:0] cmd_length,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_BITS-1:0]    in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_BITS-1:0]    out_data,
    output logic                    busy,
    output logic                    ram_enable,
    output logic [ADDRESS_BITS-1:0] ram_address,
    output logic [DATA_BITS-1:0]    ram_data_in,
    input  logic [DATA_BITS-1:0]    ram_data_out
);

    stream_state_t               state;
    stream_state_t               next_state;
    logic [ADDRESS_BITS-1:0]     addr;
    logic [ADDRESS_BITS-1:0]     remaining;
    logic [RAM_READ_LATENCY-1:0] read_pipe;
    logic                        inflight;
    logic                        issue;
    logic                        pop;
    logic                        accept;
    logic                        write_beat;
    logic                        drain_done;
    logic [2:0]                  level;
    logic [1:0]                  occupancy;

    assign inflight = read_pipe[RAM_READ_LATENCY-1];
    assign pop      = out_valid && out_ready;
    assign accept   = (state == IDLE) && cmd_valid;

    // Issue only if the buffer can still absorb this read once the in-flight one lands.
    assign level      = {1'b0, occupancy} + {2'b0, inflight} - {2'b0, pop};
    assign issue      = (state == READ) && (level < 3'(OUT_BUFFER_DEPTH));
    assign write_beat = (state == WRITE) && in_valid;
    assign drain_done = !inflight && ((occupancy == 2'd0) || (occupancy == 2'd1 && pop));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state defaults to state before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (cmd_valid) next_state = cmd_write ? WRITE : READ;
            WRITE: if (write_beat && remaining == '0) next_state = IDLE;
            READ:  if (issue && remaining == '0) next_state = DRAIN;
            DRAIN: if (drain_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        ram_enable  = 1'b0;
        ram_data_in = '0;
        case (state)
            IDLE: cmd_ready = 1'b1;
            WRITE: begin
                in_ready    = 1'b1;
                ram_enable  = in_valid;
                ram_data_in = in_data;
            end
            default: ;
        endcase
    end

    assign busy        = (state != IDLE);
    assign ram_address = addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr      <= '0;
            remaining <= '0;
            read_pipe <= '0;
        end else begin
            read_pipe <= RAM_READ_LATENCY'({read_pipe, issue});
            if (accept) begin
                addr      <= cmd_address;
                remaining <= cmd_length;
            end else if (write_beat || issue) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end

    fifo2 #(
        .DATA_BITS(DATA_BITS)
    ) u_out_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_data (ram_data_out),
        .pop       (pop),
        .head      (out_data),
        .occupancy (occupancy)
    );

    assign out_valid = (occupancy != 2'd0);

endmodule

// File: tb/tb_ram_streamer.sv
// Directed bench for ram_streamer with a behavioural registered RAM and an expected-memory image.
module tb_ram_streamer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [5:0] cmd_address = '0;
    logic [5:0] cmd_length = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       busy;
    logic       ram_enable;
    logic [5:0] ram_address;
    logic [7:0] ram_data_in;
    logic [7:0] ram_data_out;

    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] ram_mem [64];
    logic [7:0] exp_mem [64];
    logic [7:0] wdata [64];
    logic       ready_pat [12];

    always #5 clk = ~clk;

    ram_streamer #(
        .ADDRESS_BITS(6),
        .DATA_BITS(8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_address  (cmd_address),
        .cmd_length   (cmd_length),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy),
        .ram_enable   (ram_enable),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    // RAM with a registered read port; contents survive reset.
    always @(posedge clk) begin
        if (ram_enable) ram_mem[ram_address] <= ram_data_in;
        ram_data_out <= ram_mem[ram_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"},   cmd_ready,   1);
        check({tag, "_in_ready"},    in_ready,    0);
        check({tag, "_out_valid"},   out_valid,   0);
        check({tag, "_busy"},        busy,        0);
        check({tag, "_ram_enable"},  ram_enable,  0);
        check({tag, "_ram_address"}, ram_address, 0);
        check({tag, "_out_data"},    out_data,    0);
    endtask

    // Offers a command from the current time and returns just after the accepting edge.
    task automatic issue_cmd(input logic wr, input logic [5:0] a, input logic [5:0] len);
        int waited = 0;
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_address = a;
        cmd_length  = len;
        #1;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("cmd_wait_cycles", waited, 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_load(input logic [5:0] a, input int n, input int toggle);
        int k = 0;
        int c = 0;
        logic [5:0] wa;
        issue_cmd(1'b1, a, 6'(n - 1));
        while (k < n && c < 400) begin
            @(negedge clk);
            c++;
            in_valid = (toggle == 0) || c[0];
            in_data  = wdata[k];
            #1;
            check("load_busy", busy, 1);
            check("load_in_ready", in_ready, 1);
            check("load_ram_enable", ram_enable, in_valid);
            if (in_valid) begin
                wa = a + 6'(k);
                check("load_ram_address", ram_address, wa);
                check("load_ram_data_in", ram_data_in, wdata[k]);
                exp_mem[wa] = wdata[k];
                k++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("load_count", k, n);
        check("load_busy_fall", busy, 0);
        check("load_cmd_ready", cmd_ready, 1);
    endtask

    // mode 0: out_ready held high with exact timing checks; mode 1: patterned backpressure.
    task automatic do_dump(input logic [5:0] a, input int n, input int mode, input int abort_at,
                           input int hold, input logic [5:0] na, input logic [5:0] nl);
        int k = 0;
        int c = 0;
        int first_valid = 0;
        bit done = 1'b0;
        logic [5:0] ra;
        issue_cmd(1'b0, a, 6'(n - 1));
        while (!done && c < 400) begin
            @(negedge clk);
            c++;
            out_ready = (mode == 0) ? 1'b1 : ready_pat[c % 12];
            if (hold != 0) begin
                cmd_valid   = 1'b1;
                cmd_write   = 1'b0;
                cmd_address = na;
                cmd_length  = nl;
            end
            #1;
            check("dump_ram_enable", ram_enable, 0);
            check("dump_occupancy_le_2", dut.occupancy <= 2'd2, 1);
            if (!busy) begin
                done = 1'b1;
                check("dump_idle_out_valid", out_valid, 0);
                check("dump_idle_cmd_ready", cmd_ready, 1);
                if (mode == 0) check("dump_busy_fall_cycle", c, n + 3);
            end else begin
                check("dump_busy_cmd_ready", cmd_ready, 0);
                if (out_valid && first_valid == 0) begin
                    first_valid = c;
                    if (mode == 0) check("dump_first_valid_cycle", c, 3);
                end
                if (out_valid && out_ready) begin
                    ra = a + 6'(k);
                    check("dump_data", out_data, exp_mem[ra]);
                    if (mode == 0) check("dump_pop_cycle", c, 3 + k);
                    k++;
                    if (abort_at != 0 && k == abort_at) begin
                        @(posedge clk);
                        #2;
                        reset_n = 1'b0;
                        #1;
                        check_reset_values("abort");
                        out_ready = 1'b0;
                        @(negedge clk);
                        reset_n = 1'b1;
                        return;
                    end
                end
            end
        end
        check("dump_count", k, n);
        check("dump_timeout", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ready_pat[0]  = 1'b1; ready_pat[1]  = 1'b0; ready_pat[2]  = 1'b0; ready_pat[3]  = 1'b1;
        ready_pat[4]  = 1'b1; ready_pat[5]  = 1'b0; ready_pat[6]  = 1'b0; ready_pat[7]  = 1'b0;
        ready_pat[8]  = 1'b1; ready_pat[9]  = 1'b0; ready_pat[10] = 1'b1; ready_pat[11] = 1'b1;

        #23;
        check_reset_values("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Basic load and dump at address 10.
        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
        @(negedge clk);
        do_load(6'd10, 4, 0);
        @(negedge clk);
        do_dump(6'd10, 4, 0, 0, 0, 6'd0, 6'd0);

        // Burst wrapping past the top address.
        wdata[0] = 8'hA1; wdata[1] = 8'hB2; wdata[2] = 8'hC3;
        @(negedge clk);
        do_load(6'd62, 3, 0);
        @(negedge clk);
        do_dump(6'd62, 3, 0, 0, 0, 6'd0, 6'd0);

        // Full-memory load with a gappy input stream, then full dump.
        for (int i = 0; i < 64; i++) wdata[i] = 8'(i * 37 + 5);
        @(negedge clk);
        do_load(6'd20, 64, 1);
        @(negedge clk);
        do_dump(6'd20, 64, 0, 0, 0, 6'd0, 6'd0);

        // Output backpressure across the wrap point.
        @(negedge clk);
        do_dump(6'd60, 8, 1, 0, 0, 6'd0, 6'd0);

        // Reset in the middle of a dump; RAM contents must survive.
        @(negedge clk);
        do_dump(6'd5, 8, 0, 2, 0, 6'd0, 6'd0);
        @(negedge clk);
        do_dump(6'd5, 16, 0, 0, 0, 6'd0, 6'd0);

        // Command offered while busy is taken in the first idle cycle.
        @(negedge clk);
        do_dump(6'd0, 2, 0, 0, 1, 6'd30, 6'd2);
        do_dump(6'd30, 3, 0, 0, 0, 6'd0, 6'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
